mainctrl_fsm: RTL and testbench

//  Multicycle RV32 main controller FSM: produces the aluop code consumed by the ALU decoder,

---
 rtl/mainctrl_fsm_pkg.sv | 62 ++++++
 rtl/mainctrl_fsm_if.sv | 36 +++
 rtl/mainctrl_outdec.sv | 81 ++++++++
 rtl/mainctrl_fsm.sv | 93 +++++++++
 tb/tb_mainctrl_fsm.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mainctrl_fsm_pkg.sv
// rtl/mainctrl_fsm_pkg.sv - opcodes, mux codes, state encodings and decode helpers for the RV32 main controller
package mainctrl_fsm_pkg;

  localparam int XLEN    = 32;
  localparam int STATE_W = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
  localparam logic [STATE_W-1:0] S_MEMADR  = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
  localparam logic [STATE_W-1:0] S_EXECR   = 4'd6;
  localparam logic [STATE_W-1:0] S_MDUWAIT = 4'd7;
  localparam logic [STATE_W-1:0] S_EXECI   = 4'd8;
  localparam logic [STATE_W-1:0] S_ALUWB   = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH  = 4'd10;
  localparam logic [STATE_W-1:0] S_JAL     = 4'd11;
  localparam logic [STATE_W-1:0] S_AUIPC   = 4'd12;
  localparam logic [STATE_W-1:0] S_ILLEGAL = 4'd13;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_SLT, ALUOP_RTYPE} aluop_e;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1} srca_e;
  typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} srcb_e;
  typedef enum logic [1:0] {RES_ALUOUT, RES_MDR, RES_ALU} result_e;

  typedef struct packed {
    aluop_e  aluop;
    srca_e   alusrca;
    srcb_e   alusrcb;
    result_e resultsrc;
    logic    adrsrc;
    logic    irwrite;
    logic    pc_en;
    logic    memwrite;
    logic    regwrite;
    logic    mdu_start;
  } ctrl_t;

  function automatic logic is_mdu_op(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == F7_MULDIV) && ((f3 == 3'b000) || (f3 == 3'b100));
  endfunction

  function automatic logic is_base_rtype(input logic [6:0] f7, input logic [2:0] f3);
    return ((f7 == F7_BASE) &&
            ((f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010))) ||
           ((f7 == F7_ALT) && (f3 == 3'b000));
  endfunction

endpackage

// File: rtl/mainctrl_fsm_if.sv
// rtl/mainctrl_fsm_if.sv - instruction fields, status inputs and control outputs between controller and datapath
interface mainctrl_fsm_if;
  import mainctrl_fsm_pkg::*;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic               mem_ready;
  logic               alu_zero;
  logic               mdu_done;
  logic [1:0]         aluop;
  logic [1:0]         alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         resultsrc;
  logic               adrsrc;
  logic               irwrite;
  logic               pc_en;
  logic               memwrite;
  logic               regwrite;
  logic               mdu_start;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct3, funct7, mem_ready, alu_zero, mdu_done,
    output aluop, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pc_en,
           memwrite, regwrite, mdu_start, illegal, state
  );

  modport slave (
    output opcode, funct3, funct7, mem_ready, alu_zero, mdu_done,
    input  aluop, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pc_en,
           memwrite, regwrite, mdu_start, illegal, state
  );

endinterface

// File: rtl/mainctrl_outdec.sv
// rtl/mainctrl_outdec.sv - state to control-output decode; enables are gated off while reset is asserted
module mainctrl_outdec
  import mainctrl_fsm_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               reset_,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALU;
        ctrl.irwrite   = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMADR, S_EXECI: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: ctrl.adrsrc = 1'b1;
      S_MEMWB: begin
        ctrl.resultsrc = RES_MDR;
        ctrl.regwrite  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adrsrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECR: begin
        ctrl.alusrca   = SRCA_RS1;
        ctrl.aluop     = ALUOP_RTYPE;
        ctrl.mdu_start = is_mdu_op(funct7, funct3);
      end
      S_MDUWAIT: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.aluop   = ALUOP_RTYPE;
      end
      S_ALUWB: ctrl.regwrite = 1'b1;
      S_BRANCH: begin
        ctrl.alusrca = SRCA_RS1;
        if (funct3 == 3'b000) begin
          ctrl.aluop = ALUOP_SUB;
          ctrl.pc_en = alu_zero;
        end else if (funct3 == 3'b100) begin
          ctrl.aluop = ALUOP_SLT;
          ctrl.pc_en = ~alu_zero;
        end
      end
      S_JAL: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pc_en   = 1'b1;
      end
      S_AUIPC: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
      end
      default: ;
    endcase

    if (!reset_) begin
      ctrl.irwrite   = 1'b0;
      ctrl.pc_en     = 1'b0;
      ctrl.memwrite  = 1'b0;
      ctrl.regwrite  = 1'b0;
      ctrl.mdu_start = 1'b0;
    end
  end

endmodule

// File: rtl/mainctrl_fsm.sv
// rtl/mainctrl_fsm.sv - multicycle RV32 main controller: next-state logic, MDU watchdog and sticky illegal flag
module mainctrl_fsm
  import mainctrl_fsm_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64
) (
  input  logic          clock,
  input  logic          reset_,
  mainctrl_fsm_if.master bus
);

  localparam int CNT_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  logic [STATE_W-1:0] state_q, state_next;
  logic [CNT_W-1:0]   mdu_cnt;
  logic               illegal_q;
  ctrl_t              ctrl;

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_next = (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_next = S_FETCH;
      S_MEMWB, S_ALUWB: state_next = S_FETCH;
      S_EXECR: begin
        if (is_mdu_op(bus.funct7, bus.funct3))          state_next = S_MDUWAIT;
        else if (is_base_rtype(bus.funct7, bus.funct3)) state_next = S_ALUWB;
        else                                            state_next = S_ILLEGAL;
      end
      S_MDUWAIT: begin
        if (bus.mdu_done)            state_next = S_ALUWB;
        else if (mdu_cnt == CNT_LAST) state_next = S_ILLEGAL;
      end
      S_EXECI:  state_next = (bus.funct3 == 3'b000) ? S_ALUWB : S_ILLEGAL;
      S_BRANCH: state_next = ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b100)) ? S_FETCH : S_ILLEGAL;
      S_JAL, S_AUIPC: state_next = S_ALUWB;
      S_ILLEGAL: state_next = S_ILLEGAL;
      default:   state_next = S_ILLEGAL;
    endcase
  end

  // Counter restarts from zero on every entry to MDUWAIT: it only runs while waiting.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      mdu_cnt   <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_ILLEGAL) illegal_q <= 1'b1;
      if ((state_q == S_MDUWAIT) && !bus.mdu_done) mdu_cnt <= mdu_cnt + 1'b1;
      else                                         mdu_cnt <= '0;
    end
  end

  mainctrl_outdec u_outdec (
    .state     (state_q),
    .reset_    (reset_),
    .funct3    (bus.funct3),
    .funct7    (bus.funct7),
    .mem_ready (bus.mem_ready),
    .alu_zero  (bus.alu_zero),
    .ctrl      (ctrl)
  );

  assign bus.aluop     = ctrl.aluop;
  assign bus.alusrca   = ctrl.alusrca;
  assign bus.alusrcb   = ctrl.alusrcb;
  assign bus.resultsrc = ctrl.resultsrc;
  assign bus.adrsrc    = ctrl.adrsrc;
  assign bus.irwrite   = ctrl.irwrite;
  assign bus.pc_en     = ctrl.pc_en;
  assign bus.memwrite  = ctrl.memwrite;
  assign bus.regwrite  = ctrl.regwrite;
  assign bus.mdu_start = ctrl.mdu_start;
  assign bus.illegal   = illegal_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_mainctrl_fsm.sv
// tb/tb_mainctrl_fsm.sv - table-driven and directed-sequence bench for mainctrl_fsm
module tb_mainctrl_fsm;

  localparam logic [3:0] ST_F = 4'd0, ST_D = 4'd1, ST_MA = 4'd2, ST_MR = 4'd3, ST_MWB = 4'd4,
                         ST_MW = 4'd5, ST_ER = 4'd6, ST_MDW = 4'd7, ST_EI = 4'd8, ST_AWB = 4'd9,
                         ST_BR = 4'd10, ST_JAL = 4'd11, ST_ILL = 4'd13;

  // enable bundle order: {irwrite, pc_en, memwrite, regwrite, mdu_start}
  localparam logic [4:0] EN_0 = 5'b00000, EN_FE = 5'b11000, EN_PC = 5'b01000,
                         EN_MW = 5'b00100, EN_WB = 5'b00010, EN_MS = 5'b00001;

  localparam logic [31:0] IR_ADD  = 32'h007302B3, IR_LW  = 32'h00432283,
                          IR_BEQ  = 32'hFC628EE3, IR_BLT = 32'hFC62CCE3,
                          IR_DIV  = 32'h027342B3, IR_JAL = 32'h0000006F,
                          IR_SW   = 32'h0062A223, IR_BAD = 32'hFFFFFFFF,
                          IR_SLLI = 32'h00129293;

  typedef struct {
    logic        rst_n;
    logic [31:0] ir;
    logic        mr;
    logic        az;
    logic        md;
    logic [3:0]  st;
    logic [1:0]  aop;
    logic [4:0]  en;
    logic [1:0]  res;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic reset_;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  mainctrl_fsm_if bus();

  mainctrl_fsm #(.MDU_TIMEOUT(64)) dut (
    .clock  (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] observe();
    return {bus.state, bus.aluop,
            bus.irwrite, bus.pc_en, bus.memwrite, bus.regwrite, bus.mdu_start,
            bus.resultsrc, bus.illegal};
  endfunction

  function automatic logic [4:0] enables();
    return {bus.irwrite, bus.pc_en, bus.memwrite, bus.regwrite, bus.mdu_start};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] ir, input logic rst_n, input logic mr,
                       input logic az, input logic md);
    reset_        = rst_n;
    bus.opcode    = ir[6:0];
    bus.funct3    = ir[14:12];
    bus.funct7    = ir[31:25];
    bus.mem_ready = mr;
    bus.alu_zero  = az;
    bus.mdu_done  = md;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add(input logic rst_n, input logic [31:0] ir, input logic mr, input logic az,
                     input logic md, input logic [3:0] st, input logic [1:0] aop,
                     input logic [4:0] en, input logic [1:0] res, input logic ill);
    vec_t v;
    v.rst_n = rst_n; v.ir = ir; v.mr = mr; v.az = az; v.md = md;
    v.st = st; v.aop = aop; v.en = en; v.res = res; v.ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    // reset held with mem_ready high: enables must stay low
    add(0, IR_ADD, 1, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);
    add(0, IR_ADD, 1, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);
    add(1, IR_ADD, 0, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);
    add(1, IR_ADD, 0, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);
    add(1, IR_ADD, 0, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);
    // add
    add(1, IR_ADD, 1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_ADD, 0, 0, 0, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_ADD, 0, 0, 0, ST_ER,  2'b11, EN_0,  2'b00, 0);
    add(1, IR_ADD, 0, 0, 0, ST_AWB, 2'b00, EN_WB, 2'b00, 0);
    add(1, IR_ADD, 0, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);
    // lw with two wait cycles in MEMRD
    add(1, IR_LW,  1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_LW,  0, 0, 0, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_LW,  1, 0, 0, ST_MA,  2'b00, EN_0,  2'b00, 0);
    add(1, IR_LW,  0, 0, 0, ST_MR,  2'b00, EN_0,  2'b00, 0);
    add(1, IR_LW,  0, 0, 0, ST_MR,  2'b00, EN_0,  2'b00, 0);
    add(1, IR_LW,  1, 0, 0, ST_MR,  2'b00, EN_0,  2'b00, 0);
    add(1, IR_LW,  0, 0, 0, ST_MWB, 2'b00, EN_WB, 2'b01, 0);
    add(1, IR_LW,  0, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);
    // beq taken, beq not taken, blt taken
    add(1, IR_BEQ, 1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_BEQ, 0, 0, 0, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_BEQ, 0, 1, 0, ST_BR,  2'b01, EN_PC, 2'b00, 0);
    add(1, IR_BEQ, 1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_BEQ, 0, 0, 0, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_BEQ, 0, 0, 0, ST_BR,  2'b01, EN_0,  2'b00, 0);
    add(1, IR_BLT, 1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_BLT, 0, 0, 0, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_BLT, 0, 0, 0, ST_BR,  2'b10, EN_PC, 2'b00, 0);
    // div: done on the fifth MDUWAIT cycle, stray done in ALUWB ignored
    add(1, IR_DIV, 1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_DIV, 0, 0, 1, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_DIV, 0, 0, 0, ST_ER,  2'b11, EN_MS, 2'b00, 0);
    add(1, IR_DIV, 0, 0, 0, ST_MDW, 2'b11, EN_0,  2'b00, 0);
    add(1, IR_DIV, 1, 0, 0, ST_MDW, 2'b11, EN_0,  2'b00, 0);
    add(1, IR_DIV, 0, 0, 0, ST_MDW, 2'b11, EN_0,  2'b00, 0);
    add(1, IR_DIV, 0, 0, 0, ST_MDW, 2'b11, EN_0,  2'b00, 0);
    add(1, IR_DIV, 0, 0, 1, ST_MDW, 2'b11, EN_0,  2'b00, 0);
    add(1, IR_DIV, 0, 0, 1, ST_AWB, 2'b00, EN_WB, 2'b00, 0);
    // jal
    add(1, IR_JAL, 1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_JAL, 0, 0, 0, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_JAL, 0, 0, 0, ST_JAL, 2'b00, EN_PC, 2'b00, 0);
    add(1, IR_JAL, 0, 0, 0, ST_AWB, 2'b00, EN_WB, 2'b00, 0);
    // sw with one wait cycle
    add(1, IR_SW,  1, 0, 0, ST_F,   2'b00, EN_FE, 2'b10, 0);
    add(1, IR_SW,  0, 0, 0, ST_D,   2'b00, EN_0,  2'b00, 0);
    add(1, IR_SW,  0, 0, 0, ST_MA,  2'b00, EN_0,  2'b00, 0);
    add(1, IR_SW,  0, 0, 0, ST_MW,  2'b00, EN_MW, 2'b00, 0);
    add(1, IR_SW,  1, 0, 0, ST_MW,  2'b00, EN_MW, 2'b00, 0);
    add(1, IR_SW,  0, 0, 0, ST_F,   2'b00, EN_0,  2'b10, 0);

    apply(IR_ADD, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ir, vecs[i].rst_n, vecs[i].mr, vecs[i].az, vecs[i].md);
      #1;
      chk($sformatf("vec%0d", i), 32'(observe()),
          32'({vecs[i].st, vecs[i].aop, vecs[i].en, vecs[i].res, vecs[i].ill}));
      tick();
    end

    // unsupported opcode: sticky illegal, no writes even with mem_ready
    apply(IR_BAD, 1, 1, 0, 0); tick();
    apply(IR_BAD, 1, 0, 0, 0); #1;
    chk("bad_decode", 32'(bus.state), 32'(ST_D));
    tick();
    chk("bad_state", 32'(bus.state), 32'(ST_ILL));
    apply(IR_BAD, 1, 1, 1, 1);
    repeat (3) tick();
    chk("bad_sticky", 32'(bus.illegal), 32'd1);
    chk("bad_no_en", 32'(enables()), 32'(EN_0));
    chk("bad_absorb", 32'(bus.state), 32'(ST_ILL));
    apply(IR_BAD, 0, 0, 0, 0); tick();
    chk("bad_rst_ill", 32'(bus.illegal), 32'd0);
    chk("bad_rst_st", 32'(bus.state), 32'(ST_F));

    // addi slot with funct3!=000 goes illegal from EXECI
    apply(IR_SLLI, 1, 1, 0, 0); tick();
    apply(IR_SLLI, 1, 0, 0, 0); tick();
    chk("slli_execi", 32'(bus.state), 32'(ST_EI));
    tick();
    chk("slli_ill", 32'(bus.state), 32'(ST_ILL));
    apply(IR_SLLI, 0, 0, 0, 0); tick();

    // reset in the middle of a store kills the strobe immediately
    apply(IR_SW, 1, 1, 0, 0); tick();
    apply(IR_SW, 1, 0, 0, 0); tick(); tick();
    chk("sw_strobe", 32'(bus.memwrite), 32'd1);
    apply(IR_SW, 0, 1, 0, 0); #1;
    chk("sw_rst_en", 32'(enables()), 32'(EN_0));
    tick();
    chk("sw_rst_st", 32'(bus.state), 32'(ST_F));

    // MDU never answers: 64 cycles in MDUWAIT, then ILLEGAL
    apply(IR_DIV, 1, 1, 0, 0); tick();
    apply(IR_DIV, 1, 0, 0, 0); tick(); tick();
    chk("to_enter", 32'(bus.state), 32'(ST_MDW));
    repeat (63) tick();
    chk("to_last", 32'(bus.state), 32'(ST_MDW));
    tick();
    chk("to_state", 32'(bus.state), 32'(ST_ILL));
    apply(IR_DIV, 1, 1, 0, 1);
    tick(); #1;
    chk("to_ill", 32'(bus.illegal), 32'd1);
    chk("to_no_en", 32'(enables()), 32'(EN_0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
